// File: rtl/cci_mpf_prim_repl_lru_sched.sv
// cci_mpf_prim_repl_lru_sched
//
// Scheduler in front of a pseudo-LRU replacement table that has one lookup
// port and two best-effort reference ports.
//
// Lookups from N_CLIENTS requesters are arbitrated round-robin. Each winner's
// ID rides a LOOKUP_LATENCY-deep tag pipeline, so the table response is
// returned tagged with the client that issued it.
//
// A single reference stream is buffered in a small coalescing FIFO. Entries
// are issued to the two table reference ports so that neither port is used
// two cycles after its previous use. Port 1 is also never used in a cycle
// that carries a lookup.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rdy                        scheduler/table ready (mirrors lruRdy)
//   lookupReqValid/Idx/Grant   per-client lookup request, index, one-hot grant
//   lookupRspValid/Client/     response valid, owning client, victim way
//     Way/WayVec                 (index and one-hot)
//   refEn/refIdx/refWayVec     incoming reference update
//   refDropCnt                 saturating count of dropped references
//   lruRdy                     table ready
//   lruLookupEn/Idx            table lookup request
//   lruLookupRspRdy/Rsp/VecRsp table lookup response
//   lruRefEn0/Idx0/WayVec0     table reference port 0
//   lruRefEn1/Idx1/WayVec1     table reference port 1

module cci_mpf_prim_repl_lru_sched #(
   parameter int N_WAYS         = 4,
   parameter int N_ENTRIES      = 1024,
   parameter int N_CLIENTS      = 2,
   parameter int REF_FIFO_DEPTH = 4,
   parameter int LOOKUP_LATENCY = 3
) (
   input  logic                                   clk,
   input  logic                                   reset,
   output logic                                   rdy,

   input  logic [N_CLIENTS-1:0]                   lookupReqValid,
   input  logic [N_CLIENTS*$clog2(N_ENTRIES)-1:0] lookupReqIdx,
   output logic [N_CLIENTS-1:0]                   lookupReqGrant,
   output logic                                   lookupRspValid,
   output logic [$clog2(N_CLIENTS)-1:0]           lookupRspClient,
   output logic [$clog2(N_WAYS)-1:0]              lookupRspWay,
   output logic [N_WAYS-1:0]                      lookupRspWayVec,

   input  logic                                   refEn,
   input  logic [$clog2(N_ENTRIES)-1:0]           refIdx,
   input  logic [N_WAYS-1:0]                      refWayVec,
   output logic [15:0]                            refDropCnt,

   input  logic                                   lruRdy,
   output logic                                   lruLookupEn,
   output logic [$clog2(N_ENTRIES)-1:0]           lruLookupIdx,
   input  logic                                   lruLookupRspRdy,
   input  logic [$clog2(N_WAYS)-1:0]              lruLookupRsp,
   input  logic [N_WAYS-1:0]                      lruLookupVecRsp,

   output logic                                   lruRefEn0,
   output logic [$clog2(N_ENTRIES)-1:0]           lruRefIdx0,
   output logic [N_WAYS-1:0]                      lruRefWayVec0,
   output logic                                   lruRefEn1,
   output logic [$clog2(N_ENTRIES)-1:0]           lruRefIdx1,
   output logic [N_WAYS-1:0]                      lruRefWayVec1
);

   localparam int IDXW = $clog2(N_ENTRIES);
   localparam int CW   = $clog2(N_CLIENTS);
   localparam int PW   = $clog2(REF_FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Lookup arbitration
   // ------------------------------------------------------------------
   logic [CW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] win_id, win_hi, win_any;
   logic          win_hi_found;
   logic          grant_en;

   // Scan from the top down so the last hit is the lowest index. win_hi is
   // the first valid client at or after the pointer; if there is none, the
   // search wraps to the lowest valid client overall.
   always_comb begin
      win_hi       = '0;
      win_any      = '0;
      win_hi_found = 1'b0;
      for (int c = N_CLIENTS - 1; c >= 0; c--) begin
         if (lookupReqValid[c]) begin
            win_any = CW'(c);
            if (CW'(c) >= rr_ptr_q) begin
               win_hi       = CW'(c);
               win_hi_found = 1'b1;
            end
         end
      end
      win_id   = win_hi_found ? win_hi : win_any;
      grant_en = lruRdy && (|lookupReqValid) && !reset;

      rr_ptr_d = rr_ptr_q;
      if (grant_en) begin
         rr_ptr_d = (win_id == CW'(N_CLIENTS - 1)) ? '0 : win_id + CW'(1);
      end
   end

   assign lookupReqGrant = grant_en ? (N_CLIENTS'(1) << win_id) : '0;
   assign lruLookupEn    = grant_en;
   assign lruLookupIdx   = lookupReqIdx[win_id*IDXW +: IDXW];
   assign rdy            = lruRdy;

   // ------------------------------------------------------------------
   // Response tag pipeline
   // ------------------------------------------------------------------
   logic [LOOKUP_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [CW-1:0]             tag_id_q [LOOKUP_LATENCY];
   logic [CW-1:0]             tag_id_d [LOOKUP_LATENCY];

   always_comb begin
      tag_vld_d[0] = grant_en;
      tag_id_d[0]  = win_id;
      for (int s = 1; s < LOOKUP_LATENCY; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end
   end

   // The table resets with the scheduler. Masking the response during reset
   // keeps stale in-flight responses from leaking out.
   assign lookupRspValid  = lruLookupRspRdy && !reset;
   assign lookupRspClient = tag_id_q[LOOKUP_LATENCY-1];
   assign lookupRspWay    = lruLookupRsp;
   assign lookupRspWayVec = lruLookupVecRsp;

   // The table must answer exactly when the matching tag reaches the tail.
   assert property (@(posedge clk) disable iff (reset)
                    lruLookupRspRdy == tag_vld_q[LOOKUP_LATENCY-1]);

   // ------------------------------------------------------------------
   // Reference FIFO and port scheduling
   // ------------------------------------------------------------------
   logic [IDXW-1:0]   fifo_idx_q [REF_FIFO_DEPTH];
   logic [IDXW-1:0]   fifo_idx_d [REF_FIFO_DEPTH];
   logic [N_WAYS-1:0] fifo_vec_q [REF_FIFO_DEPTH];
   logic [N_WAYS-1:0] fifo_vec_d [REF_FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, newest_ptr;
   logic [PW:0]       cnt_q, cnt_d;
   logic [1:0]        p0_hist_q, p0_hist_d, p1_hist_q, p1_hist_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic              fifo_empty, fifo_full;
   logic              issue_p0, issue_p1, deq;
   logic              coalesce, enq, drop;

   // hist[1] marks an issue two cycles ago. The table is still doing its
   // read/modify/write for that set, so that port is skipped this cycle.
   // Port 1 also shares the table with the lookup port.
   always_comb begin
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == (PW+1)'(REF_FIFO_DEPTH));
      issue_p0   = 1'b0;
      issue_p1   = 1'b0;
      if (lruRdy && !fifo_empty && !reset) begin
         if (!p0_hist_q[1]) begin
            issue_p0 = 1'b1;
         end else if (!p1_hist_q[1] && !grant_en) begin
            issue_p1 = 1'b1;
         end
      end
      deq       = issue_p0 || issue_p1;
      p0_hist_d = {p0_hist_q[0], issue_p0};
      p1_hist_d = {p1_hist_q[0], issue_p1};
   end

   // A matching reference merges into the newest entry. If that entry is
   // the only one and it leaves this cycle, append a new entry instead.
   // Because a dequeue frees a slot in the same cycle, a full FIFO still
   // accepts the new reference.
   always_comb begin
      newest_ptr = wr_ptr_q - PW'(1);
      coalesce   = refEn && !fifo_empty &&
                   (fifo_idx_q[newest_ptr] == refIdx) &&
                   !(deq && (cnt_q == (PW+1)'(1)));
      enq        = refEn && !coalesce && (!fifo_full || deq);
      drop       = refEn && !coalesce && !enq;

      fifo_idx_d = fifo_idx_q;
      fifo_vec_d = fifo_vec_q;
      if (coalesce) begin
         fifo_vec_d[newest_ptr] = fifo_vec_q[newest_ptr] | refWayVec;
      end
      if (enq) begin
         fifo_idx_d[wr_ptr_q] = refIdx;
         fifo_vec_d[wr_ptr_q] = refWayVec;
      end

      wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d      = cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
      drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   assign lruRefEn0     = issue_p0;
   assign lruRefIdx0    = fifo_idx_q[rd_ptr_q];
   assign lruRefWayVec0 = fifo_vec_q[rd_ptr_q];
   assign lruRefEn1     = issue_p1;
   assign lruRefIdx1    = fifo_idx_q[rd_ptr_q];
   assign lruRefWayVec1 = fifo_vec_q[rd_ptr_q];
   assign refDropCnt    = drop_cnt_q;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         tag_vld_q  <= '0;
         for (int s = 0; s < LOOKUP_LATENCY; s++) begin
            tag_id_q[s] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         p0_hist_q  <= '0;
         p1_hist_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         tag_vld_q  <= tag_vld_d;
         tag_id_q   <= tag_id_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         p0_hist_q  <= p0_hist_d;
         p1_hist_q  <= p1_hist_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage needs no reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      fifo_idx_q <= fifo_idx_d;
      fifo_vec_q <= fifo_vec_d;
   end

endmodule

// File: tb/tb_cci_mpf_prim_repl_lru_sched.sv
// tb_cci_mpf_prim_repl_lru_sched
//
// Testbench for cci_mpf_prim_repl_lru_sched using the default parameters.
// The bench plays the LRU table: a 3-cycle lookup delay line whose returned
// way is idx[2:1]. A queue-based reference model tracks the round-robin
// pointer, in-flight responses, the reference FIFO contents, per-port issue
// cycles and the drop count. The DUT outputs are checked against that model
// on every falling edge. Directed sequences add literal expectations.

module tb_cci_mpf_prim_repl_lru_sched;

   localparam int NCL   = 2;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rdy;
   logic [1:0]  lookupReqValid = '0;
   logic [19:0] lookupReqIdx = '0;
   logic [1:0]  lookupReqGrant;
   logic        lookupRspValid;
   logic        lookupRspClient;
   logic [1:0]  lookupRspWay;
   logic [3:0]  lookupRspWayVec;
   logic        refEn = 1'b0;
   logic [9:0]  refIdx = '0;
   logic [3:0]  refWayVec = '0;
   logic [15:0] refDropCnt;
   logic        lruRdy = 1'b0;
   logic        lruLookupEn;
   logic [9:0]  lruLookupIdx;
   logic        lruLookupRspRdy;
   logic [1:0]  lruLookupRsp;
   logic [3:0]  lruLookupVecRsp;
   logic        lruRefEn0, lruRefEn1;
   logic [9:0]  lruRefIdx0, lruRefIdx1;
   logic [3:0]  lruRefWayVec0, lruRefWayVec1;

   int nVec = 0;
   int nMis = 0;
   int cyc  = 0;
   logic chk = 1'b0;

   cci_mpf_prim_repl_lru_sched dut (
      .clk             (clk),
      .reset           (reset),
      .rdy             (rdy),
      .lookupReqValid  (lookupReqValid),
      .lookupReqIdx    (lookupReqIdx),
      .lookupReqGrant  (lookupReqGrant),
      .lookupRspValid  (lookupRspValid),
      .lookupRspClient (lookupRspClient),
      .lookupRspWay    (lookupRspWay),
      .lookupRspWayVec (lookupRspWayVec),
      .refEn           (refEn),
      .refIdx          (refIdx),
      .refWayVec       (refWayVec),
      .refDropCnt      (refDropCnt),
      .lruRdy          (lruRdy),
      .lruLookupEn     (lruLookupEn),
      .lruLookupIdx    (lruLookupIdx),
      .lruLookupRspRdy (lruLookupRspRdy),
      .lruLookupRsp    (lruLookupRsp),
      .lruLookupVecRsp (lruLookupVecRsp),
      .lruRefEn0       (lruRefEn0),
      .lruRefIdx0      (lruRefIdx0),
      .lruRefWayVec0   (lruRefWayVec0),
      .lruRefEn1       (lruRefEn1),
      .lruRefIdx1      (lruRefIdx1),
      .lruRefWayVec1   (lruRefWayVec1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Table stand-in: fixed 3-cycle latency, victim way = idx[2:1]
   logic [2:0] tV;
   logic [9:0] tIdx [3];
   always @(posedge clk) begin
      if (reset) begin
         tV <= '0;
      end else begin
         tV      <= {tV[1:0], lruLookupEn};
         tIdx[0] <= lruLookupIdx;
         tIdx[1] <= tIdx[0];
         tIdx[2] <= tIdx[1];
      end
   end
   assign lruLookupRspRdy = tV[2];
   assign lruLookupRsp    = tIdx[2][2:1];
   assign lruLookupVecRsp = 4'b0001 << lruLookupRsp;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic rdyIn, input logic [1:0] reqV,
                                input logic rEn, input logic [9:0] rIdx, input logic [3:0] rVec);
      lruRdy         = rdyIn;
      lookupReqValid = reqV;
      refEn          = rEn;
      refIdx         = rIdx;
      refWayVec      = rVec;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] reqIdxOf(input int c);
      return lookupReqIdx[c*10 +: 10];
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      int         due;
      int         client;
      logic [9:0] idx;
   } rsp_t;

   typedef struct {
      logic [9:0] idx;
      logic [3:0] vec;
   } ref_t;

   rsp_t rspQ[$];
   ref_t refQ[$];
   bit   p0Used[int];
   bit   p1Used[int];
   int   mRr = 0;
   int   mDrop = 0;

   int   cc, cSel, expW, expPort;
   logic expEn, expRsp;
   rsp_t rh, rNew;
   ref_t fh, fNew;

   always @(negedge clk) begin
      if (chk) begin
         cc = cyc;

         expEn = 1'b0;
         expW  = 0;
         if (!reset && lruRdy) begin
            for (int k = 0; k < NCL; k++) begin
               cSel = (mRr + k) % NCL;
               if (!expEn && lookupReqValid[cSel]) begin
                  expEn = 1'b1;
                  expW  = cSel;
               end
            end
         end
         checkOutput("rdy", rdy, lruRdy);
         checkOutput("grant", lookupReqGrant, expEn ? (32'd1 << expW) : 32'd0);
         checkOutput("lookupEn", lruLookupEn, expEn);
         if (expEn) checkOutput("lookupIdx", lruLookupIdx, reqIdxOf(expW));

         expRsp = !reset && (rspQ.size() > 0) && (rspQ[0].due == cc);
         checkOutput("rspValid", lookupRspValid, expRsp);
         if (expRsp) begin
            rh = rspQ[0];
            checkOutput("rspClient", lookupRspClient, rh.client);
            checkOutput("rspWay", lookupRspWay, rh.idx[2:1]);
            checkOutput("rspWayVec", lookupRspWayVec, 32'd1 << rh.idx[2:1]);
         end

         // A port is usable unless it issued exactly two cycles ago; port 1
         // also yields to a lookup in the same cycle.
         expPort = -1;
         if (!reset && lruRdy && refQ.size() > 0) begin
            if (!p0Used.exists(cc - 2)) expPort = 0;
            else if (!p1Used.exists(cc - 2) && !expEn) expPort = 1;
         end
         checkOutput("refEn0", lruRefEn0, expPort == 0);
         checkOutput("refEn1", lruRefEn1, expPort == 1);
         if (expPort >= 0) begin
            fh = refQ[0];
            if (expPort == 0) begin
               checkOutput("refIdx0", lruRefIdx0, fh.idx);
               checkOutput("refVec0", lruRefWayVec0, fh.vec);
            end else begin
               checkOutput("refIdx1", lruRefIdx1, fh.idx);
               checkOutput("refVec1", lruRefWayVec1, fh.vec);
            end
         end
         checkOutput("dropCnt", refDropCnt, mDrop);

         if (reset) begin
            rspQ.delete();
            refQ.delete();
            p0Used.delete();
            p1Used.delete();
            mRr   = 0;
            mDrop = 0;
         end else begin
            if (expRsp) void'(rspQ.pop_front());
            if (expEn) begin
               rNew.due    = cc + LAT;
               rNew.client = expW;
               rNew.idx    = reqIdxOf(expW);
               rspQ.push_back(rNew);
               mRr = (expW + 1) % NCL;
            end
            if (expPort >= 0) begin
               void'(refQ.pop_front());
               if (expPort == 0) p0Used[cc] = 1'b1;
               else p1Used[cc] = 1'b1;
            end
            if (refEn) begin
               if (refQ.size() > 0 && refQ[refQ.size()-1].idx == refIdx) begin
                  fNew = refQ[refQ.size()-1];
                  fNew.vec = fNew.vec | refWayVec;
                  refQ[refQ.size()-1] = fNew;
               end else if (refQ.size() < DEPTH) begin
                  fNew.idx = refIdx;
                  fNew.vec = refWayVec;
                  refQ.push_back(fNew);
               end else if (mDrop < 65535) begin
                  mDrop++;
               end
            end
         end
      end
   end

   // ---------------- directed sequences ----------------
   initial begin
      applyStimulus(1'b0, 2'b00, 1'b0, 10'd0, 4'd0);
      lookupReqIdx = {10'd9, 10'd5};
      reset = 1'b1;
      step();
      chk = 1'b1;
      step();
      #1;
      checkOutput("rst_grant", lookupReqGrant, 0);
      checkOutput("rst_lookupEn", lruLookupEn, 0);
      checkOutput("rst_refEn0", lruRefEn0, 0);
      checkOutput("rst_refEn1", lruRefEn1, 0);
      checkOutput("rst_rspValid", lookupRspValid, 0);
      checkOutput("rst_dropCnt", refDropCnt, 0);
      reset = 1'b0;

      $display("[TB] round-robin with both clients");
      applyStimulus(1'b1, 2'b11, 1'b0, 10'd0, 4'd0);
      for (int k = 0; k < 8; k++) begin
         #1;
         checkOutput("rr_grant", lookupReqGrant, (k % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput("rr_idx", lruLookupIdx, (k % 2 == 0) ? 10'd5 : 10'd9);
         checkOutput("rr_rspValid", lookupRspValid, k >= 3);
         if (k >= 3) begin
            checkOutput("rr_rspClient", lookupRspClient, (k - 3) % 2);
            checkOutput("rr_rspWay", lookupRspWay, ((k - 3) % 2 == 0) ? 2 : 0);
         end
         step();
      end
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      repeat (4) step();

      $display("[TB] pointer wrap");
      applyStimulus(1'b1, 2'b10, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("wrap_c1", lookupReqGrant, 2'b10);
      step();
      applyStimulus(1'b1, 2'b11, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("wrap_c0", lookupReqGrant, 2'b01);
      step();
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      repeat (5) step();

      $display("[TB] coalesce");
      applyStimulus(1'b0, 2'b00, 1'b1, 10'd7, 4'b0001);
      #1;
      checkOutput("coal_hold0", lruRefEn0, 0);
      step();
      applyStimulus(1'b0, 2'b00, 1'b1, 10'd7, 4'b0100);
      #1;
      checkOutput("coal_hold1", lruRefEn0, 0);
      step();
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("coal_en0", lruRefEn0, 1);
      checkOutput("coal_en1", lruRefEn1, 0);
      checkOutput("coal_idx", lruRefIdx0, 10'd7);
      checkOutput("coal_vec", lruRefWayVec0, 4'b0101);
      step();
      #1;
      checkOutput("coal_empty0", lruRefEn0, 0);
      checkOutput("coal_empty1", lruRefEn1, 0);
      step();

      $display("[TB] port alternation");
      for (int j = 0; j < 7; j++) begin
         if (j < 6) applyStimulus(1'b1, 2'b00, 1'b1, 10'(j + 1), 4'(1 << (j % 4)));
         else applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
         #1;
         if (j >= 1) begin
            checkOutput("alt_en0", lruRefEn0, (j == 1 || j == 2 || j == 5 || j == 6));
            checkOutput("alt_en1", lruRefEn1, (j == 3 || j == 4));
            checkOutput("alt_idx", (j == 3 || j == 4) ? lruRefIdx1 : lruRefIdx0, j);
         end
         step();
      end
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      repeat (3) step();

      $display("[TB] overflow and saturation");
      applyStimulus(1'b0, 2'b11, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("nordy_grant", lookupReqGrant, 0);
      checkOutput("nordy_lookupEn", lruLookupEn, 0);
      step();
      for (int j = 0; j < 6; j++) begin
         applyStimulus(1'b0, 2'b00, 1'b1, 10'(20 + j), 4'b0010);
         step();
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("drop_two", refDropCnt, 16'd2);
      applyStimulus(1'b0, 2'b00, 1'b1, 10'd30, 4'b1000);
      repeat (70000) step();
      applyStimulus(1'b0, 2'b00, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("drop_sat", refDropCnt, 16'hFFFF);
      step();
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("drain_first", lruRefIdx0, 10'd20);
      repeat (6) step();

      $display("[TB] reset with lookups in flight");
      applyStimulus(1'b1, 2'b11, 1'b0, 10'd0, 4'd0);
      repeat (2) step();
      reset = 1'b1;
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      step();
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         #1;
         checkOutput("flush_rspValid", lookupRspValid, 0);
         step();
      end
      applyStimulus(1'b1, 2'b01, 1'b0, 10'd0, 4'd0);
      #1;
      checkOutput("post_grant", lookupReqGrant, 2'b01);
      checkOutput("post_idx", lruLookupIdx, 10'd5);
      step();
      applyStimulus(1'b1, 2'b00, 1'b0, 10'd0, 4'd0);
      for (int j = 1; j <= 4; j++) begin
         #1;
         checkOutput("post_rspValid", lookupRspValid, j == 3);
         if (j == 3) begin
            checkOutput("post_rspClient", lookupRspClient, 0);
            checkOutput("post_rspWay", lookupRspWay, 2);
            checkOutput("post_rspVec", lookupRspWayVec, 4'b0100);
         end
         step();
      end

      chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/cci_mpf_prim_repl_lru_sched.md
Name: cci_mpf_prim_repl_lru_sched

Overview:
- Scheduler in front of a pseudo-LRU replacement table that has one lookup port and two best-effort reference ports.
- Arbitrates lookups from N_CLIENTS requesters round-robin and returns each response tagged with its client ID.
- Buffers a single reference stream in a coalescing FIFO and issues references to the two table ports without creating known internal conflicts.
- Sits between cache tag pipelines and the LRU table.

Parameters:
N_WAYS, 4, ways per set; table vector width.
N_ENTRIES, 1024, sets; IDXW = clog2(N_ENTRIES).
N_CLIENTS, 2, lookup requesters (≥2); CW = clog2(N_CLIENTS).
REF_FIFO_DEPTH, 4, reference buffer entries (power of 2, ≥2).
LOOKUP_LATENCY, 3, cycles from lruLookupEn to lruLookupRspRdy.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rdy  out  1  scheduler and table ready (= lruRdy)
lookupReqValid  in  N_CLIENTS  per-client lookup request
lookupReqIdx  in  N_CLIENTS*IDXW  per-client set index; client c occupies bits [c*IDXW +: IDXW]
lookupReqGrant  out  N_CLIENTS  one-hot; request accepted this cycle
lookupRspValid  out  1  response valid
lookupRspClient  out  CW  client owning the response
lookupRspWay  out  clog2(N_WAYS)  victim way index
lookupRspWayVec  out  N_WAYS  victim way, one-hot
refEn  in  1  reference update valid
refIdx  in  IDXW  referenced set
refWayVec  in  N_WAYS  referenced ways
refDropCnt  out  16  saturating count of dropped references
lruRdy  in  1  table ready
lruLookupEn / lruLookupIdx  out  1 / IDXW  table lookup request
lruLookupRspRdy / lruLookupRsp / lruLookupVecRsp  in  1 / clog2(N_WAYS) / N_WAYS  table response
lruRefEn0 / lruRefIdx0 / lruRefWayVec0  out  1 / IDXW / N_WAYS  table ref port 0
lruRefEn1 / lruRefIdx1 / lruRefWayVec1  out  1 / IDXW / N_WAYS  table ref port 1

Behaviour:
- Reset: all outputs 0 (grants, lruLookupEn, lruRefEn*, lookupRspValid, refDropCnt). FIFO empty. RR pointer = 0. Tag pipeline and port-history bits cleared.
- Reset mid-operation: in-flight lookups are discarded; lookupRspValid stays 0 until a post-reset grant matures.
- Lookup arbitration (combinational):
  - When lruRdy=1 and any request is valid, grant the first valid client at or after the RR pointer.
  - Assert lruLookupEn=1 and drive lruLookupIdx from the winner in the same cycle.
  - RR pointer advances to winner+1 (mod N_CLIENTS) on grant.
  - lruRdy=0: no grants.
  - Requesters hold valid and index until granted.
- Response path:
  - Winner ID enters a LOOKUP_LATENCY-deep shift register alongside a valid bit.
  - lookupRspValid = lruLookupRspRdy. Way and vector pass through combinationally; lookupRspClient = tag at the pipeline tail.
  - Simulation assertion: lruLookupRspRdy must equal the tail valid bit.
  - Throughput: one lookup per cycle.
- Reference FIFO:
  - refEn=1 and idx equals the newest un-issued entry: OR refWayVec into that entry (coalesce). A coalesce is never a drop.
  - Else if not full: enqueue.
  - Else: drop and increment refDropCnt, saturating at 0xFFFF.
  - Enqueue/coalesce and dequeue may occur in the same cycle. If the coalesce target is being dequeued that cycle, enqueue instead.
  - Full with simultaneous dequeue: the new entry is accepted, not dropped.
  - Pointers wrap mod REF_FIFO_DEPTH.
- Reference issue (at most one per cycle, only when lruRdy=1 and FIFO non-empty):
  - p0_hist[1:0] and p1_hist[1:0] record port issues in the prior 2 cycles.
  - Port 0 is eligible if no port-0 issue occurred 2 cycles earlier (avoids table read/modify/write blocking).
  - Port 1 is eligible if no port-1 issue occurred 2 cycles earlier and lruLookupEn=0 this cycle.
  - Prefer port 0, else port 1, else hold.
  - Issued entry drives lruRefEn/Idx/WayVec for exactly 1 cycle, then dequeues.
- Non-issuing ports hold lruRefEn*=0. Idx/WayVec are don't-care when En=0.

Test Plan:
- Reset, then lruRdy=1; both clients valid continuously, idx 5 and 9 → grants alternate c0, c1, c0…; responses arrive 3 cycles after each grant, tagged 0, 1, 0…
- Only c1 valid, then c0 joins → c1 granted; next cycle c0 granted (pointer = 0 after c1 grant).
- Refs idx 7 vec 0001 then idx 7 vec 0100 on consecutive cycles, issue blocked by lruRdy=0 → one FIFO entry; after lruRdy=1, single port-0 issue idx 7 vec 0101.
- Refs to idx 1..6 every cycle, lookups held off → port pattern 0,0,1,1,0,0…; no port reuses within 2 cycles.
- lruRdy=0 with 6 distinct refs, depth 4 → 4 buffered, refDropCnt=2; 70000 further drops → counter holds 0xFFFF.
- Reset asserted with 2 lookups in flight → no lookupRspValid after reset; first post-reset grant responds normally after 3 cycles.
